// File: rtl/adc_lut_loader_if.sv
// adc_lut_loader_if: 8-bit node stream from the PS into the LUT loader.
//   tdata  : tree node value
//   tvalid : node valid (producer)
//   tready : node accepted when tvalid & tready (consumer)
// master = stream producer (PS side), slave = adc_lut_loader.
interface adc_lut_loader_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_lut_loader.sv
// adc_lut_loader: programs the adc_driver threshold tree and capture enable
// over the shared 32-bit GPIO word {7'b0, w_clk, data[7:0], addr[15:0]}.
// Each write is SETUP_CYC of stable addr/data, STROBE_CYC with w_clk high,
// then GAP_CYC with w_clk low before the next write may start.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_load      : pulse, begin loading NUM_NODES nodes to addr 0..N-1
//   abort           : pulse, stop the load after the current write
//   s_axis          : node stream (slave modport)
//   cap_start/stop  : pulse, request CAPTURE_ADDR <= 1 / 0
//   gpio_out        : GPIO word to adc_driver
//   scaler_run      : high once a complete table is resident
//   busy            : a write or load is in progress
//   load_done       : pulse when the last node write completes
//   aborted         : pulse when an abort takes effect
//   lut_checksum    : 16-bit wrapping sum of accepted nodes
//                     (only with ADC_LUT_CHECKSUM_EN defined)
module adc_lut_loader #(
  parameter int NUM_NODES    = 255,
  parameter int CAPTURE_ADDR = 256,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int GAP_CYC      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_load,
  input  logic                abort,
  adc_lut_loader_if.slave     s_axis,
  input  logic                cap_start,
  input  logic                cap_stop,
  output logic [31:0]         gpio_out,
  output logic                scaler_run,
  output logic                busy,
  output logic                load_done,
  output logic                aborted
`ifdef ADC_LUT_CHECKSUM_EN
  , output logic [15:0]       lut_checksum
`endif
);

  localparam int WR_CYC = SETUP_CYC + STROBE_CYC + GAP_CYC;
  localparam int TW     = $clog2(WR_CYC + 1);
  localparam int CW     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  localparam logic [CW-1:0] LAST_NODE   = CW'(NUM_NODES - 1);
  localparam logic [TW-1:0] SETUP_LAST  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] STRB_BEG    = TW'(SETUP_CYC);
  localparam logic [TW-1:0] STRB_END    = TW'(SETUP_CYC + STROBE_CYC);
  localparam logic [TW-1:0] WR_LAST     = TW'(WR_CYC - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, GAP, CAPW, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr;           // cycles spent in the current state
  logic [CW-1:0] cnt;           // node counter
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic          abort_q;
  logic          cap_pend, cap_val;
  logic          cap_ret_done;  // CAPW was entered from DONE
  logic          hs, in_load, rest, abort_now, w_clk;

  assign hs        = (state == FETCH) && s_axis.tvalid;
  assign in_load   = (state == FETCH) || (state == SETUP) ||
                     (state == STROBE) || (state == GAP);
  assign rest      = (state == IDLE) || (state == DONE);
  // The pulse itself counts so an abort on the deciding cycle is not lost.
  assign abort_now = abort_q | abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        // start_load beats a pending capture; the capture stays pending.
        if (start_load)    state_nxt = FETCH;
        else if (cap_pend) state_nxt = CAPW;
      end
      FETCH: begin
        if (hs)             state_nxt = SETUP;
        else if (abort_now) state_nxt = IDLE;
      end
      SETUP:  if (tmr == SETUP_LAST)  state_nxt = STROBE;
      STROBE: if (tmr == STROBE_LAST) state_nxt = GAP;
      GAP: begin
        // A completed table wins over an abort raised during its last write.
        if (tmr == GAP_LAST) begin
          if (cnt == LAST_NODE) state_nxt = DONE;
          else if (abort_now)   state_nxt = IDLE;
          else                  state_nxt = FETCH;
        end
      end
      CAPW: if (tmr == WR_LAST) state_nxt = cap_ret_done ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: gpio_out is forced to 0 outside write states so an async reset
  // clears it at once.
  always_comb begin
    w_clk = (state == STROBE) ||
            ((state == CAPW) && (tmr >= STRB_BEG) && (tmr < STRB_END));
    busy  = !rest;
    if ((state == SETUP) || (state == STROBE) || (state == GAP) || (state == CAPW))
      gpio_out = {7'b0, w_clk, data_q, addr_q};
    else
      gpio_out = '0;
  end

  assign s_axis.tready = (state == FETCH);

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr          <= '0;
      cnt          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      abort_q      <= 1'b0;
      cap_pend     <= 1'b0;
      cap_val      <= 1'b0;
      cap_ret_done <= 1'b0;
      scaler_run   <= 1'b0;
      load_done    <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      tmr       <= (state_nxt != state) ? '0 : tmr + 1'b1;
      load_done <= (state == GAP) && (state_nxt == DONE);
      aborted   <= in_load && (state_nxt == IDLE);

      if ((state == GAP) && (state_nxt == DONE)) scaler_run <= 1'b1;
      if (rest && start_load) begin
        scaler_run <= 1'b0;
        cnt        <= '0;
      end
      if (hs) begin
        addr_q <= 16'(cnt);
        data_q <= s_axis.tdata;
      end
      if ((state == GAP) && (state_nxt == FETCH)) cnt <= cnt + 1'b1;

      if (in_load && abort) abort_q <= 1'b1;
      if ((state_nxt == IDLE) || (state_nxt == DONE)) abort_q <= 1'b0;

      if ((state_nxt == CAPW) && (state != CAPW)) begin
        cap_pend     <= 1'b0;
        addr_q       <= 16'(CAPTURE_ADDR);
        data_q       <= {7'b0, cap_val};
        cap_ret_done <= (state == DONE);
      end
      // Newest request wins, stop beats start; placed last so a request on
      // the CAPW entry cycle stays pending.
      if (cap_start || cap_stop) begin
        cap_pend <= 1'b1;
        cap_val  <= !cap_stop;
      end
    end
  end

`ifdef ADC_LUT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     lut_checksum <= '0;
    else if (rest && start_load) lut_checksum <= '0;
    else if (hs)                 lut_checksum <= lut_checksum + 16'(s_axis.tdata);
  end
`endif

endmodule

// File: tb/tb_adc_lut_loader.sv
module tb_adc_lut_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_load = 1'b0, abort = 1'b0, cap_start = 1'b0, cap_stop = 1'b0;
  logic [31:0] gpio_out;
  logic        scaler_run, busy, load_done, aborted;
`ifdef ADC_LUT_CHECKSUM_EN
  logic [15:0] lut_checksum;
`endif

  adc_lut_loader_if s_axis ();

  adc_lut_loader dut (
    .clk(clk), .rst(rst), .start_load(start_load), .abort(abort),
    .s_axis(s_axis), .cap_start(cap_start), .cap_stop(cap_stop),
    .gpio_out(gpio_out), .scaler_run(scaler_run), .busy(busy),
    .load_done(load_done), .aborted(aborted)
`ifdef ADC_LUT_CHECKSUM_EN
    , .lut_checksum(lut_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] data; logic [15:0] addr;} wr_t;
  typedef struct {logic st; logic sp; logic [7:0] exp;} cap_vec_t;

  int   checks = 0, errors = 0;
  wr_t  node_q[$], cap_q[$];
  cap_vec_t cv[3];
  bit   stop_drv = 0, check_spacing = 0, loading = 0;
  int   n_writes = 0, ld_seen = 0, ab_seen = 0, cyc = 0, last_rise = 0;
  logic [15:0] sum_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: decode GPIO writes on the rising w_clk and compare to scoreboard.
  logic        prev_w = 1'b0;
  int          hi_len = 0;
  logic [23:0] rise_word = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_w  = 1'b0;
      hi_len  = 0;
      loading = 0;
    end else begin
      if (start_load && !busy) begin
        loading  = 1;
        n_writes = 0;
      end
      if (gpio_out[24] && !prev_w) begin
        rise_word = gpio_out[23:0];
        hi_len = 1;
        chk("pad_zero", 32'(gpio_out[31:25]), 32'd0);
        if (rise_word[15:0] == 16'd256) begin
          chk("cap_deferred", 32'(loading), 32'd0);
          if (cap_q.size() == 0) chk("cap_unexpected", 32'(rise_word), 32'hFFFFFFFF);
          else chk("cap_write", 32'(rise_word), 32'(cap_q.pop_front()));
        end else begin
          n_writes++;
          if (node_q.size() == 0) chk("node_unexpected", 32'(rise_word), 32'hFFFFFFFF);
          else chk("node_write", 32'(rise_word), 32'(node_q.pop_front()));
          if (check_spacing && n_writes > 1) chk("spacing", cyc - last_rise, 9);
          last_rise = cyc;
        end
      end else if (gpio_out[24] && prev_w) begin
        hi_len++;
        chk("strobe_stable", 32'(gpio_out[23:0]), 32'(rise_word));
      end else if (!gpio_out[24] && prev_w) begin
        chk("strobe_len", hi_len, 2);
      end
      prev_w = gpio_out[24];
      if (load_done) begin
        ld_seen++;
        loading = 0;
        chk("done_scaler_run", 32'(scaler_run), 32'd1);
        chk("done_writes", n_writes, 255);
`ifdef ADC_LUT_CHECKSUM_EN
        chk("done_checksum", 32'(lut_checksum), 32'(sum_model));
`endif
      end
      if (aborted) begin
        ab_seen++;
        loading = 0;
      end
    end
  end

  // mode 0: value=index, tvalid held; 1: value=index, random tvalid; 2: all 0xFF
  task automatic drive_load(input int mode);
    sum_model = '0;
    for (int i = 0; i < 255 && !stop_drv; i++) begin
      logic [7:0] v;
      bit got;
      int t;
      v = (mode == 2) ? 8'hFF : 8'(i);
      got = 0;
      t = 0;
      s_axis.tdata = v;
      while (!got && !stop_drv) begin
        s_axis.tvalid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (s_axis.tvalid && s_axis.tready) begin
          got = 1;
          node_q.push_back(wr_t'({v, 16'(i)}));
          sum_model = sum_model + 16'(v);
        end
        @(posedge clk); #1;
        t++;
        if (t > 200) begin
          chk("fetch_timeout", 32'd1, 32'd0);
          stop_drv = 1;
        end
      end
    end
    s_axis.tvalid = 1'b0;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
  endtask

  task automatic wait_done(input int ld0);
    for (int t = 0; t < 400 && ld_seen == ld0; t++) @(posedge clk);
    #1;
    chk("load_done_once", ld_seen - ld0, 1);
  endtask

  initial begin
    cv[0] = '{st: 1'b1, sp: 1'b0, exp: 8'd1};
    cv[1] = '{st: 1'b0, sp: 1'b1, exp: 8'd0};
    cv[2] = '{st: 1'b1, sp: 1'b1, exp: 8'd0};
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_tready", 32'(s_axis.tready), 32'd0);
    chk("rst_scaler_run", 32'(scaler_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Idle capture requests from the vector table
    foreach (cv[k]) begin
      cap_start = cv[k].st;
      cap_stop  = cv[k].sp;
      cap_q.push_back(wr_t'({cv[k].exp, 16'd256}));
      @(posedge clk); #1;
      cap_start = 1'b0;
      cap_stop  = 1'b0;
      @(posedge clk); #1;
      chk("cap_busy", 32'(busy), 32'd1);
      for (int t = 0; t < 20 && busy; t++) begin @(posedge clk); #1; end
      chk("cap_served", cap_q.size(), 0);
      chk("cap_idle", 32'(busy), 32'd0);
    end

    // Full load, tvalid held, capture request at node 100 deferred to the end
    check_spacing = 1;
    begin
      int ld0;
      ld0 = ld_seen;
      pulse_start();
      fork
        drive_load(0);
        begin
          for (int t = 0; t < 3000 && n_writes < 100; t++) @(posedge clk);
          #1;
          cap_start = 1'b1;
          cap_q.push_back(wr_t'({8'd1, 16'd256}));
          @(posedge clk); #1;
          cap_start = 1'b0;
        end
      join
      wait_done(ld0);
      for (int t = 0; t < 30 && (busy || cap_q.size() != 0); t++) begin @(posedge clk); #1; end
      chk("load_node_q_empty", node_q.size(), 0);
      chk("load_cap_after_done", cap_q.size(), 0);
      chk("load_scaler_run", 32'(scaler_run), 32'd1);
    end

    // Abort during the strobe of node 40
    begin
      int ab0, ld0;
      ab0 = ab_seen;
      ld0 = ld_seen;
      pulse_start();
      chk("start_clears_run", 32'(scaler_run), 32'd0);
      fork
        drive_load(0);
        begin
          for (int t = 0; t < 1000 && n_writes < 41; t++) @(posedge clk);
          #1;
          abort = 1'b1;
          chk("abort_in_strobe", 32'(gpio_out[24]), 32'd1);
          @(posedge clk); #1;
          abort = 1'b0;
          for (int t = 0; t < 30 && ab_seen == ab0; t++) @(posedge clk);
          #1;
          stop_drv = 1;
        end
      join
      stop_drv = 0;
      chk("aborted_pulse", ab_seen - ab0, 1);
      chk("abort_writes", n_writes, 41);
      chk("abort_scaler_run", 32'(scaler_run), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_no_done", ld_seen - ld0, 0);
      chk("abort_q_empty", node_q.size(), 0);
    end

    // Restart from addr 0 with random tvalid
    check_spacing = 0;
    begin
      int ld0;
      ld0 = ld_seen;
      pulse_start();
      drive_load(1);
      wait_done(ld0);
      chk("rand_node_q_empty", node_q.size(), 0);
    end

    // Reset in the middle of a strobe
    begin
      int w0;
      pulse_start();
      fork
        drive_load(0);
        begin
          for (int t = 0; t < 200 && n_writes < 3; t++) @(posedge clk);
          #2;
          chk("pre_rst_strobe", 32'(gpio_out[24]), 32'd1);
          rst = 1'b1;
          #1;
          chk("mid_rst_gpio", gpio_out, 32'd0);
          chk("mid_rst_busy", 32'(busy), 32'd0);
          chk("mid_rst_tready", 32'(s_axis.tready), 32'd0);
          chk("mid_rst_scaler_run", 32'(scaler_run), 32'd0);
          stop_drv = 1;
        end
      join
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      stop_drv = 0;
      node_q.delete();
      w0 = n_writes;
      repeat (20) @(posedge clk); #1;
      chk("post_rst_no_write", n_writes, w0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_gpio", gpio_out, 32'd0);
    end

`ifdef ADC_LUT_CHECKSUM_EN
    begin
      int ld0;
      ld0 = ld_seen;
      pulse_start();
      drive_load(2);
      wait_done(ld0);
      chk("checksum_ff", 32'(lut_checksum), 32'h0000FE01);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/adc_lut_loader.md
Name: adc_lut_loader

Overview:
Sequencer that programs the adc_driver threshold search tree and capture control over the shared 32-bit GPIO word.
- Consumes pre-ordered tree nodes from the PS as an 8-bit stream and writes them to GPIO addresses 0..NUM_NODES-1 with correctly timed w_clk strobes.
- Arbitrates capture start/stop writes to CAPTURE_ADDR against table loading.
- Releases adc_input_scaler_run once a complete table is resident.

Parameters:
NUM_NODES, 255, tree nodes per load (root at addr 0, breadth-first order)
CAPTURE_ADDR, 256, GPIO address of the ADC capture enable register
SETUP_CYC, 1, cycles addr/data are stable before w_clk rises
STROBE_CYC, 2, cycles w_clk is held high
GAP_CYC, 5, cycles after w_clk falls before the next write may start

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start_load  in  1  single-cycle pulse: begin a table load
abort  in  1  single-cycle pulse: stop the load after the current write
s_axis_tdata  in  8  tree node value
s_axis_tvalid  in  1  node valid
s_axis_tready  out  1  node accepted when tvalid&tready
cap_start  in  1  pulse: request write CAPTURE_ADDR <= 1
cap_stop  in  1  pulse: request write CAPTURE_ADDR <= 0
gpio_out  out  32  {7'b0, w_clk, data[7:0], addr[15:0]} to adc_driver gpio_in
scaler_run  out  1  level to adc_driver adc_input_scaler_run
busy  out  1  any write or load in progress
load_done  out  1  single-cycle pulse when node NUM_NODES-1 write completes
aborted  out  1  single-cycle pulse when an abort takes effect

Behaviour:
- Reset values: gpio_out=0, s_axis_tready=0, scaler_run=0, busy=0, load_done=0, aborted=0. Node counter=0. Capture request flags are cleared.
- Reset mid-operation: gpio_out returns to 0 immediately, including mid-strobe. No write is resumed.
- States: IDLE, FETCH, SETUP, STROBE, GAP, CAPW (capture write), DONE.
- IDLE/DONE, start_load:
  - Clear scaler_run and the node counter.
  - Go to FETCH.
  - start_load takes priority over a pending capture request in the same cycle; the capture request stays pending.
- FETCH:
  - s_axis_tready=1.
  - On handshake, latch tdata, drive addr=counter and data=tdata, then go to SETUP.
  - No handshake: stay in FETCH with gpio_out at 0.
- SETUP (SETUP_CYC) -> STROBE (STROBE_CYC, w_clk=1) -> GAP (GAP_CYC, w_clk=0). addr/data are held from SETUP through the end of GAP.
- At the end of GAP:
  - counter==NUM_NODES-1: pulse load_done, set scaler_run=1, go to DONE.
  - Otherwise: increment the counter and go to FETCH.
- Minimum node-to-node period is 1+SETUP_CYC+STROBE_CYC+GAP_CYC = 9 cycles. A full load takes at least 2295 cycles.
- abort:
  - Latched during any load state.
  - Honoured at the end of GAP, or immediately in FETCH if no handshake occurs that cycle.
  - The w_clk strobe is never truncated.
  - On taking effect: pulse aborted, scaler_run stays 0, go to IDLE.
- Capture requests:
  - cap_start or cap_stop sets a pending flag with value 1 or 0. cap_stop wins if both are asserted in the same cycle. A newer request overwrites an older pending one.
  - Served only from IDLE or DONE, via CAPW: addr=CAPTURE_ADDR, data={7'b0,val}, using the same SETUP/STROBE/GAP timing.
  - Afterwards, return to the state CAPW was entered from.
  - Requests arriving during a load are deferred until the load ends (DONE, or IDLE after abort).
- busy=1 in every state except IDLE and DONE.
- gpio_out[31:25] is always 0.
- Addresses are zero-extended to 16 bits.

Optional Feature:
Macro ADC_LUT_CHECKSUM_EN.
- With the macro:
  - Extra output lut_checksum[15:0] holds the 16-bit wrapping sum of every node accepted during the current load.
  - Cleared on start_load and on rst.
  - Valid when load_done pulses.
  - Frozen until the next start_load.
- Without the macro: the port and the adder are absent.

Test Plan:
- Load 255 nodes with value=index&0xFF, tvalid held high -> exactly 255 writes at addr 0..254, data correct, w_clk high 2 cycles each, 9-cycle spacing, load_done after write 254, scaler_run=1 on the next cycle.
- Toggle tvalid randomly during a load -> tready only in FETCH, no node lost or duplicated, data/addr stable throughout each strobe.
- cap_start pulse at node 100 -> no write to addr 256 until after load_done, then one write addr=256 data=1. cap_start and cap_stop in the same cycle while idle -> single write data=0.
- abort during the STROBE of node 40 -> strobe completes fully, then aborted pulses, scaler_run=0, busy=0, 41 writes observed. New start_load restarts from addr 0.
- rst asserted mid-STROBE -> gpio_out=0 and all outputs at reset values asynchronously. After release the block sits in IDLE with no spurious w_clk.
- With ADC_LUT_CHECKSUM_EN: load of 255 nodes all 0xFF -> lut_checksum=0xFE01.
